lsu_align: RTL and testbench

Load/store alignment unit sitting directly upstream of the data memory. It takes byte-addressed RV32I load/store requests from the execute stage and converts them into word-indexed full-word reads and writes on the dmem port. It performs read-modify-write for sub-word stores, since dmem stores zero the unselected lanes. It splits accesses that cross a word boundary into two word operations, and extracts and sign- or zero-extends load data. The pipeline stalls on req_ready.

---
 rtl/lsu_align.sv | 173 +++++++++++++++++
 tb/tb_lsu_align.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Converts RV32I byte-addressed loads/stores into full-word dmem
//            reads/writes with read-modify-write and word-crossing splits.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [3:0]  wmem,
    output logic [4:0]  rmem,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [4:0] c_RMEM_WORD = 5'b01111;
    localparam logic [3:0] c_WMEM_WORD = 4'b1111;

    logic [2:0]        r_state;
    logic              r_we;
    logic              r_fault;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [ADDR_W-1:0] r_word;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf0;
    logic [31:0]       r_buf1;

    logic              w_req_fault;
    logic              w_req_full;
    logic [3:0]        w_size_mask;
    logic [7:0]        w_lane_mask;
    logic              w_cross;
    logic [ADDR_W-1:0] w_word1;
    logic [63:0]       w_wdata_sh;
    logic [31:0]       w_load_word;
    logic [31:0]       w_load_ext;
    logic              w_unused_addr;

    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

    assign w_req_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    assign w_req_full  = req_we && (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00);

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    // Byte lanes touched across the {w1, w0} pair; any upper-half lane means a split.
    assign w_lane_mask = {4'b0000, w_size_mask} << r_off;
    assign w_cross     = |w_lane_mask[7:4];
    assign w_word1     = r_word + ADDR_W'(1);
    assign w_wdata_sh  = {32'd0, r_wdata} << {r_off, 3'b000};
    assign w_load_word = 32'({r_buf1, r_buf0} >> {r_off, 3'b000});

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{~r_funct3[2] & w_load_word[7]}}, w_load_word[7:0]};
            2'b01:   w_load_ext = {{16{~r_funct3[2] & w_load_word[15]}}, w_load_word[15:0]};
            default: w_load_ext = w_load_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_fault  <= 1'b0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_word   <= '0;
            r_wdata  <= 32'd0;
            r_buf0   <= 32'd0;
            r_buf1   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_fault  <= w_req_fault;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        r_word   <= req_addr[ADDR_W+1:2];
                        r_wdata  <= req_wdata;
                        if (w_req_fault)     r_state <= S_RESP;
                        else if (w_req_full) r_state <= S_WR0;
                        else                 r_state <= S_RD0;
                    end
                end
                S_RD0: begin
                    r_buf0 <= load_data;
                    if (w_cross)   r_state <= S_RD1;
                    else if (r_we) r_state <= S_WR0;
                    else           r_state <= S_RESP;
                end
                S_RD1: begin
                    r_buf1  <= load_data;
                    r_state <= r_we ? S_WR0 : S_RESP;
                end
                S_WR0:   r_state <= w_cross ? S_WR1 : S_RESP;
                S_WR1:   r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = 32'd0;
        wmem       = 4'b0000;
        rmem       = 5'b00000;
        mem_addr   = 32'd0;
        store_data = 32'd0;
        case (r_state)
            S_RD0: begin
                rmem     = c_RMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, r_word};
            end
            S_RD1: begin
                rmem     = c_RMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, w_word1};
            end
            S_WR0: begin
                wmem     = c_WMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, r_word};
                for (int i = 0; i < 4; i++)
                    store_data[8*i +: 8] = w_lane_mask[i] ? w_wdata_sh[8*i +: 8] : r_buf0[8*i +: 8];
            end
            S_WR1: begin
                wmem     = c_WMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, w_word1};
                for (int i = 0; i < 4; i++)
                    store_data[8*i +: 8] = w_lane_mask[4+i] ? w_wdata_sh[32+8*i +: 8] : r_buf1[8*i +: 8];
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                if (!r_we && !r_fault)
                    resp_rdata = w_load_ext;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_align
// Purpose  : Directed, table-driven self-checking bench for lsu_align with a
//            behavioural word memory on the dmem port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [3:0]  wmem;
    logic [4:0]  rmem;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    lsu_align #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .wmem       (wmem),
        .rmem       (rmem),
        .mem_addr   (mem_addr),
        .store_data (store_data),
        .load_data  (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign load_data = mem[mem_addr[11:0]];

    always @(posedge clk) begin
        if (wmem == 4'b1111)
            mem[mem_addr[11:0]] = store_data;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b010;
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [11:0] w0;
        logic [11:0] w1;
        int          lat;
        int          acc;
        logic        done;
        w0 = v.addr[13:2];
        w1 = w0 + 12'd1;
        mem[w0] = v.m0;
        mem[w1] = v.m1;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), {31'd0, req_ready}, 32'd1);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        lat  = 0;
        acc  = 0;
        done = 1'b0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (wmem != 4'd0 || rmem != 5'd0) acc++;
            chk($sformatf("v%0d_addr_hi", idx), {12'd0, mem_addr[31:12]}, 32'd0);
            if (resp_valid) done = 1'b1;
            else chk($sformatf("v%0d_ready_busy", idx), {31'd0, req_ready}, 32'd0);
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        if (done) begin
            chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
            chk($sformatf("v%0d_fault", idx), {31'd0, resp_fault}, {31'd0, v.fault});
            chk($sformatf("v%0d_mem_w0", idx), mem[w0], v.e0);
            chk($sformatf("v%0d_mem_w1", idx), mem[w1], v.e1);
            if (v.fault) chk($sformatf("v%0d_fault_no_access", idx), acc, 0);
            @(negedge clk);
            chk($sformatf("v%0d_resp_pulse", idx), {31'd0, resp_valid}, 32'd0);
        end
    endtask

    initial begin
        //            we    f3      addr          wdata         m0            m1            rdata         flt   lat e0            e1
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hFFFF_FFDE, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'h0000_00DE, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hFFFF_DEAD, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'h0000_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{1'b1, 3'b000, 32'h0000_0011, 32'h1234_56A5, 32'h1122_3344, 32'h0,       32'h0,         1'b0, 3, 32'h1122_A544, 32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_000E, 32'h0,        32'h4433_2211, 32'h8877_6655, 32'h6655_4433, 1'b0, 3, 32'h4433_2211, 32'h8877_6655};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_3FFF, 32'hCAFE_BEEF, 32'h0,        32'h0,        32'h0,         1'b0, 5, 32'hEF00_0000, 32'h0000_00BE};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 32'h5555_5555, 32'h9999_9999, 32'h0,       1'b0, 2, 32'h1234_5678, 32'h9999_9999};
        vecs[9]  = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'h0,         1'b1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1'b1, 3'b111, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0,       32'h0,         1'b1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[11] = '{1'b0, 3'b001, 32'h0000_0017, 32'h0,        32'hAABB_CCDD, 32'h1122_33F4, 32'hFFFF_F4AA, 1'b0, 3, 32'hAABB_CCDD, 32'h1122_33F4};
        vecs[12] = '{1'b1, 3'b010, 32'h0000_0022, 32'hAABB_CCDD, 32'h1111_1111, 32'h2222_2222, 32'h0,       1'b0, 5, 32'hCCDD_1111, 32'h2222_AABB};
        vecs[13] = '{1'b1, 3'b001, 32'h0000_0030, 32'hFFFF_1234, 32'h8765_4321, 32'h0,       32'h0,         1'b0, 3, 32'h8765_1234, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'hFFFF_0010, 32'h0,        32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[15] = '{1'b0, 3'b000, 32'h0000_0041, 32'h0,        32'h0000_8000, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 32'h0000_8000, 32'h0};

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready",      {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_wmem_rmem",  {23'd0, wmem, rmem}, 32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        chk("rst_store_data", store_data,          32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i], i);

        // SB read-modify-write: observe RD0 then WR0 on the dmem port.
        mem[4] = 32'h1122_3344;
        @(negedge clk);
        drive_req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5);
        @(negedge clk);
        chk("sb_rd0_addr", mem_addr,           32'd4);
        chk("sb_rd0_rmem", {27'd0, rmem},      32'h0000_000F);
        @(negedge clk);
        chk("sb_wr0_wmem", {28'd0, wmem},      32'h0000_000F);
        chk("sb_wr0_data", store_data,         32'h1122_A544);
        chk("sb_wr0_addr", mem_addr,           32'd4);
        @(negedge clk);
        chk("sb_resp",     {31'd0, resp_valid}, 32'd1);
        chk("sb_mem",      mem[4],             32'h1122_A544);

        // Reset asserted while in RD1 of a crossing load.
        mem[3] = 32'h4433_2211;
        mem[4] = 32'h8877_6655;
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h0000_000E, 32'h0);
        @(posedge clk);
        #1;
        chk("rd1_addr", mem_addr,      32'd4);
        chk("rd1_rmem", {27'd0, rmem}, 32'h0000_000F);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready",      {31'd0, req_ready},  32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_wmem_rmem",  {23'd0, wmem, rmem}, 32'd0);
        chk("abort_mem_addr",   mem_addr,            32'd0);
        chk("abort_store_data", store_data,          32'd0);
        chk("abort_rdata",      resp_rdata,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[6], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
